// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the Frogger playfield logic: scheduler state encoding,
// lane direction / base-speed constants and default screen geometry.
// -----------------------------------------------------------------------------
package frogger_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_MOVE  = 3'd2,
        ST_CHECK = 3'd3,
        ST_HIT   = 3'd4,
        ST_WIN   = 3'd5
    } state_e;

    localparam int DEF_TILE_SIZE  = 32;
    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int MAX_CARS       = 4;

    // Even lanes travel right, odd lanes travel left.
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    // Lane n runs at BASE_SPEED_OFS + n (+ level) pixels per movement frame.
    localparam logic [3:0] BASE_SPEED_OFS = 4'd1;

endpackage

// File: rtl/car_lane_step.sv
// -----------------------------------------------------------------------------
// car_lane_step
// Combinational next-X for one car: moves X by speed in the given direction
// and wraps horizontally modulo H_VISIBLE_AREA using 11-bit intermediates.
// Ports:
//   x_i      current car X (0 .. H_VISIBLE_AREA-1)
//   speed_i  pixels per step
//   dir_i    DIR_RIGHT / DIR_LEFT
//   x_o      wrapped next X
// -----------------------------------------------------------------------------
module car_lane_step
    import frogger_pkg::*;
#(
    parameter int H_VISIBLE_AREA = DEF_H_VISIBLE
) (
    input  logic [9:0] x_i,
    input  logic [3:0] speed_i,
    input  logic       dir_i,
    output logic [9:0] x_o
);

    localparam logic [10:0] H_MOD = 11'(H_VISIBLE_AREA);

    logic [10:0] x_w;
    logic [10:0] s_w;
    logic [10:0] sum_w;

    always_comb begin
        x_w   = {1'b0, x_i};
        s_w   = {7'b0, speed_i};
        sum_w = x_w + s_w;
        if (dir_i == DIR_RIGHT) begin
            x_o = (sum_w >= H_MOD) ? 10'(sum_w - H_MOD) : 10'(sum_w);
        end else begin
            x_o = (x_w < s_w) ? 10'(x_w + H_MOD - s_w) : 10'(x_w - s_w);
        end
    end

endmodule

// File: rtl/car_scheduler.sv
// -----------------------------------------------------------------------------
// car_scheduler
// Frame-synchronous traffic controller: owns car sprite positions, advances
// one car per cycle after every FRAME_DIV-th frame tick, then checks each car
// against the latched frog position and pulses hit or win.
// Optional feature macro: CAR_SPEEDUP_EN (each win raises a 0..7 speed level,
// a hit clears it). Without the macro the level is a constant 0.
// Ports:
//   i_Clk, i_Rst_L            clock, synchronous active-low reset
//   i_Frame_Tick              one-cycle pulse at start of vertical blanking
//   i_Start                   level, starts play from IDLE
//   i_Frog_X, i_Frog_Y        frog top-left corner
//   o_Car_1X..4X, 1Y..4Y      car top-left corners (registered)
//   o_Hit, o_Win              one-cycle result pulses
//   o_State                   current FSM state
//
// state | meaning
// IDLE  | cars frozen, waiting for i_Start
// WAIT  | counting frame ticks up to FRAME_DIV
// MOVE  | stepping car idx, one per cycle
// CHECK | OR overlap of car idx into sticky hit flag
// HIT   | pulse o_Hit, back to IDLE
// WIN   | pulse o_Win, back to IDLE
// -----------------------------------------------------------------------------
module car_scheduler
    import frogger_pkg::*;
#(
    parameter int TILE_SIZE      = DEF_TILE_SIZE,
    parameter int H_VISIBLE_AREA = DEF_H_VISIBLE,
    parameter int V_VISIBLE_AREA = DEF_V_VISIBLE,
    parameter int NB_CARS        = MAX_CARS,
    parameter int FRAME_DIV      = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic [9:0] i_Frog_X,
    input  logic [9:0] i_Frog_Y,
    output logic [9:0] o_Car_1X,
    output logic [9:0] o_Car_2X,
    output logic [9:0] o_Car_3X,
    output logic [9:0] o_Car_4X,
    output logic [9:0] o_Car_1Y,
    output logic [9:0] o_Car_2Y,
    output logic [9:0] o_Car_3Y,
    output logic [9:0] o_Car_4Y,
    output logic       o_Hit,
    output logic       o_Win,
    output logic [2:0] o_State
);

    localparam logic [1:0]  LAST_IDX = 2'(NB_CARS - 1);
    localparam logic [3:0]  FDIV     = 4'(FRAME_DIV);
    localparam logic [10:0] TILE_W   = 11'(TILE_SIZE);

    function automatic logic [9:0] lane_y_f(input int n);
        return 10'(V_VISIBLE_AREA - TILE_SIZE * (n + 2));
    endfunction

    function automatic logic [9:0] reset_x_f(input int n);
        return 10'(n * (H_VISIBLE_AREA / 4));
    endfunction

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] frog_x_q, frog_x_d;
    logic [9:0] frog_y_q, frog_y_d;
    logic       hit_acc_q, hit_acc_d;
    logic       hit_q, hit_d;
    logic       win_q, win_d;
    logic [9:0] car_x_q [MAX_CARS];
    logic [9:0] car_x_d [MAX_CARS];
    logic [2:0] level;

`ifdef CAR_SPEEDUP_EN
    localparam logic [2:0] LVL_MAX = 3'd7;
    logic [2:0] lvl_q, lvl_d;
    assign level = lvl_q;
`else
    assign level = 3'd0;
`endif

    logic [3:0]  speed;
    logic        dir;
    logic [9:0]  step_x;
    logic [10:0] cx, fx, cy, fy, dx, dy;
    logic        overlap;

    assign speed = {2'b00, idx_q} + BASE_SPEED_OFS + {1'b0, level};
    assign dir   = idx_q[0] ? DIR_LEFT : DIR_RIGHT;

    car_lane_step #(
        .H_VISIBLE_AREA (H_VISIBLE_AREA)
    ) u_step (
        .x_i     (car_x_q[idx_q]),
        .speed_i (speed),
        .dir_i   (dir),
        .x_o     (step_x)
    );

    // Overlap ignores horizontal wrap: plain absolute distance on both axes.
    always_comb begin
        cx      = {1'b0, car_x_q[idx_q]};
        fx      = {1'b0, frog_x_q};
        cy      = {1'b0, lane_y_f(int'(idx_q))};
        fy      = {1'b0, frog_y_q};
        dx      = (cx >= fx) ? (cx - fx) : (fx - cx);
        dy      = (cy >= fy) ? (cy - fy) : (fy - cy);
        overlap = (dx < TILE_W) && (dy < TILE_W);
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        frog_x_d  = frog_x_q;
        frog_y_d  = frog_y_q;
        hit_acc_d = hit_acc_q;
        hit_d     = 1'b0;
        win_d     = 1'b0;
        for (int n = 0; n < MAX_CARS; n++) begin
            car_x_d[n] = car_x_q[n];
        end
`ifdef CAR_SPEEDUP_EN
        lvl_d = lvl_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'd0;
                end
            end
            ST_WAIT: begin
                // Compare one cycle after the counting tick; this sets the
                // MOVE start at T+1 relative to the last tick.
                if (cnt_q == FDIV) begin
                    cnt_d     = 4'd0;
                    frog_x_d  = i_Frog_X;
                    frog_y_d  = i_Frog_Y;
                    idx_d     = 2'd0;
                    hit_acc_d = 1'b0;
                    state_d   = ST_MOVE;
                end else if (i_Frame_Tick) begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_MOVE: begin
                car_x_d[idx_q] = step_x;
                if (idx_q == LAST_IDX) begin
                    idx_d   = 2'd0;
                    state_d = ST_CHECK;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_CHECK: begin
                hit_acc_d = hit_acc_q | overlap;
                if (idx_q == LAST_IDX) begin
                    idx_d = 2'd0;
                    if (hit_acc_q | overlap) begin
                        state_d = ST_HIT;
                    end else if (frog_y_q == 10'd0) begin
                        state_d = ST_WIN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_HIT: begin
                hit_d   = 1'b1;
                state_d = ST_IDLE;
`ifdef CAR_SPEEDUP_EN
                lvl_d = 3'd0;
`endif
            end
            ST_WIN: begin
                win_d   = 1'b1;
                state_d = ST_IDLE;
`ifdef CAR_SPEEDUP_EN
                if (lvl_q != LVL_MAX) begin
                    lvl_d = lvl_q + 3'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            cnt_q     <= 4'd0;
            frog_x_q  <= 10'd0;
            frog_y_q  <= 10'd0;
            hit_acc_q <= 1'b0;
            hit_q     <= 1'b0;
            win_q     <= 1'b0;
            for (int n = 0; n < MAX_CARS; n++) begin
                car_x_q[n] <= reset_x_f(n);
            end
`ifdef CAR_SPEEDUP_EN
            lvl_q <= 3'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            frog_x_q  <= frog_x_d;
            frog_y_q  <= frog_y_d;
            hit_acc_q <= hit_acc_d;
            hit_q     <= hit_d;
            win_q     <= win_d;
            for (int n = 0; n < MAX_CARS; n++) begin
                car_x_q[n] <= car_x_d[n];
            end
`ifdef CAR_SPEEDUP_EN
            lvl_q <= lvl_d;
`endif
        end
    end

    assign o_Car_1X = car_x_q[0];
    assign o_Car_2X = car_x_q[1];
    assign o_Car_3X = car_x_q[2];
    assign o_Car_4X = car_x_q[3];
    assign o_Car_1Y = lane_y_f(0);
    assign o_Car_2Y = lane_y_f(1);
    assign o_Car_3Y = lane_y_f(2);
    assign o_Car_4Y = lane_y_f(3);
    assign o_Hit    = hit_q;
    assign o_Win    = win_q;
    assign o_State  = state_q;

endmodule

// File: tb/tb_car_scheduler.sv
// -----------------------------------------------------------------------------
// tb_car_scheduler
// Directed bench for car_scheduler: a FRAME_DIV=1 instance for movement, wrap,
// hit/win and reset behaviour, and a FRAME_DIV=3 instance for frame division.
// -----------------------------------------------------------------------------
module tb_car_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_l, start, tick, start3, tick3;
    logic [9:0] frog_x, frog_y;

    logic [9:0] c1x, c2x, c3x, c4x, c1y, c2y, c3y, c4y;
    logic       hit, win;
    logic [2:0] state;

    logic [9:0] d1x, d2x, d3x, d4x, d1y, d2y, d3y, d4y;
    logic       hit3, win3;
    logic [2:0] state3;

    int checks   = 0;
    int failures = 0;
    int mx [4];
    int level    = 0;

    car_scheduler #(.FRAME_DIV(1)) dut (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame_Tick(tick), .i_Start(start),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
        .o_Car_1X(c1x), .o_Car_2X(c2x), .o_Car_3X(c3x), .o_Car_4X(c4x),
        .o_Car_1Y(c1y), .o_Car_2Y(c2y), .o_Car_3Y(c3y), .o_Car_4Y(c4y),
        .o_Hit(hit), .o_Win(win), .o_State(state)
    );

    car_scheduler #(.FRAME_DIV(3)) dut3 (
        .i_Clk(clk), .i_Rst_L(rst_l), .i_Frame_Tick(tick3), .i_Start(start3),
        .i_Frog_X(frog_x), .i_Frog_Y(frog_y),
        .o_Car_1X(d1x), .o_Car_2X(d2x), .o_Car_3X(d3x), .o_Car_4X(d4x),
        .o_Car_1Y(d1y), .o_Car_2Y(d2y), .o_Car_3Y(d3y), .o_Car_4Y(d4y),
        .o_Hit(hit3), .o_Win(win3), .o_State(state3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int gx(input int n);
        case (n)
            0:       return int'(c1x);
            1:       return int'(c2x);
            2:       return int'(c3x);
            default: return int'(c4x);
        endcase
    endfunction

    task automatic check_all(input string tag);
        for (int n = 0; n < 4; n++) chk($sformatf("%s_car%0d", tag, n), gx(n), mx[n]);
    endtask

    task automatic model_move();
        for (int n = 0; n < 4; n++) begin
            int s;
            s = n + 1 + level;
            if (n % 2 == 0) mx[n] = (mx[n] + s) % 640;
            else            mx[n] = (mx[n] - s + 640) % 640;
        end
    endtask

    task automatic model_win();
`ifdef CAR_SPEEDUP_EN
        if (level < 7) level++;
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic frame_main();
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 12; k++) step();
        model_move();
    endtask

    task automatic frame3();
        tick3 = 1'b1;
        step();
        tick3 = 1'b0;
        for (int k = 0; k < 12; k++) step();
    endtask

    initial begin
        rst_l = 1'b0; start = 1'b0; tick = 1'b0; start3 = 1'b0; tick3 = 1'b0;
        frog_x = 10'd300; frog_y = 10'd100;
        mx[0] = 0; mx[1] = 160; mx[2] = 320; mx[3] = 480;
        step(); step(); step();

        // Reset state
        chk("rst_car0x", int'(c1x), 0);
        chk("rst_car1x", int'(c2x), 160);
        chk("rst_car2x", int'(c3x), 320);
        chk("rst_car3x", int'(c4x), 480);
        chk("rst_car0y", int'(c1y), 416);
        chk("rst_car1y", int'(c2y), 384);
        chk("rst_car2y", int'(c3y), 352);
        chk("rst_car3y", int'(c4y), 320);
        chk("rst_state", int'(state), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_win", int'(win), 0);
        rst_l = 1'b1;
        step();

        // First movement frame
        pulse_start();
        chk("start_state", int'(state), 1);
        frame_main();
        chk("f1_car0", int'(c1x), 1);
        chk("f1_car1", int'(c2x), 158);
        chk("f1_car2", int'(c3x), 323);
        chk("f1_car3", int'(c4x), 476);
        chk("f1_hit", int'(hit), 0);
        chk("f1_win", int'(win), 0);
        chk("f1_state", int'(state), 1);

        // Left wrap on car1 (speed 2): reaches 0 after 80 frames, then 638
        for (int f = 2; f <= 80; f++) frame_main();
        chk("f80_car1", int'(c2x), 0);
        frame_main();
        chk("f81_car1_wrap", int'(c2x), 638);
        check_all("f81");

        // Right wrap on car0 (speed 1): 639 then 0
        for (int f = 82; f <= 639; f++) frame_main();
        chk("f639_car0", int'(c1x), 639);
        frame_main();
        chk("f640_car0_wrap", int'(c1x), 0);
        chk("f640_car1", int'(c2x), 160);
        chk("f640_car2", int'(c3x), 320);
        chk("f640_car3", int'(c4x), 480);

        // Hit: frog at (10,416), car0 moves to X=1
        frog_x = 10'd10; frog_y = 10'd416;
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("hit_pre", int'(hit), 0);
        step();
        chk("hit_pulse", int'(hit), 1);
        chk("hit_state_idle", int'(state), 0);
        step();
        chk("hit_fall", int'(hit), 0);
        model_move();
        level = 0;
        chk("hit_car0_kept", int'(c1x), 1);
        check_all("hit_kept");

        // Win: frog on row 0, far from cars
        frog_x = 10'd300; frog_y = 10'd0;
        pulse_start();
        tick = 1'b1;
        step();
        tick = 1'b0;
        for (int k = 0; k < 9; k++) step();
        chk("win_pre", int'(win), 0);
        step();
        chk("win_pulse", int'(win), 1);
        chk("win_hit_low", int'(hit), 0);
        chk("win_state_idle", int'(state), 0);
        step();
        chk("win_fall", int'(win), 0);
        model_move();
        model_win();
        chk("win_car0", int'(c1x), 2);

        pulse_start();
        frame_main();
        model_win();
`ifdef CAR_SPEEDUP_EN
        chk("post_win_car0", int'(c1x), 4);
`else
        chk("post_win_car0", int'(c1x), 3);
`endif
        check_all("post_win");

        // FRAME_DIV=3 instance, including a tick dropped during MOVE
        frog_x = 10'd300; frog_y = 10'd100;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        frame3();
        frame3();
        chk("div3_t2_car0", int'(d1x), 0);
        tick3 = 1'b1;
        step();
        tick3 = 1'b0;
        step();
        tick3 = 1'b1;
        step();
        tick3 = 1'b0;
        chk("div3_in_move", int'(state3), 2);
        for (int k = 0; k < 10; k++) step();
        chk("div3_t3_car0", int'(d1x), 1);
        chk("div3_t3_car1", int'(d2x), 158);
        frame3();
        frame3();
        chk("div3_t5_car0", int'(d1x), 1);
        frame3();
        chk("div3_t6_car0", int'(d1x), 2);
        chk("div3_t6_car1", int'(d2x), 156);

        // Reset in the middle of MOVE, after car0 has stepped
        pulse_start();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        step();
        chk("mid_car0_moved", int'(c1x), (mx[0] + 1 + level) % 640);
        chk("mid_car1_old", int'(c2x), mx[1]);
        chk("mid_state", int'(state), 2);
        rst_l = 1'b0;
        step();
        chk("mrst_car0", int'(c1x), 0);
        chk("mrst_car1", int'(c2x), 160);
        chk("mrst_car2", int'(c3x), 320);
        chk("mrst_car3", int'(c4x), 480);
        chk("mrst_state", int'(state), 0);
        rst_l = 1'b1;
        for (int k = 0; k < 12; k++) step();
        chk("mrst_still_idle", int'(state), 0);
        chk("mrst_hit", int'(hit), 0);
        chk("mrst_win", int'(win), 0);
        chk("mrst_car0_frozen", int'(c1x), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_scheduler.md
# car_scheduler

Frame-synchronous traffic controller for the Frogger playfield: owns the positions of the car sprites, advances them once per movement frame with per-lane speed, direction and horizontal wrap-around, then checks each car against the frog and flags hit or win. It sits between the frog movement logic and `Sprite_Display`. Its registered car X/Y outputs drive the display's car position inputs directly and only change during vertical blanking.

## Interface
- `TILE_SIZE`, 32, sprite edge length in pixels
- `H_VISIBLE_AREA`, 640, visible width; wrap modulus for car X
- `V_VISIBLE_AREA`, 480, visible height; lane Y base
- `NB_CARS`, 4, number of cars / lanes (1..4)
- `FRAME_DIV`, 1, movement step every FRAME_DIV frame ticks (1..15)
- `i_Clk`  in  1  pixel clock; single clock domain
- `i_Rst_L`  in  1  synchronous, active-low reset
- `i_Frame_Tick`  in  1  one-cycle pulse at start of vertical blanking
- `i_Start`  in  1  level; begins play when in IDLE
- `i_Frog_X`, `i_Frog_Y`  in  10 each  frog top-left corner
- `o_Car_1X`..`o_Car_4X`, `o_Car_1Y`..`o_Car_4Y`  out  10 each  car top-left corners
- `o_Hit`  out  1  one-cycle pulse: frog overlapped a car
- `o_Win`  out  1  one-cycle pulse: frog reached row 0
- `o_State`  out  3  current FSM state encoding

## Operation
- Lane n (0-based), car n:
  - Y = V_VISIBLE_AREA − TILE_SIZE·(n+2). Defaults give 416, 384, 352, 320.
  - Even n moves right, odd n moves left.
  - speed = n + 1 + level. Level is 0 unless the speedup feature is enabled.
- Reset values:
  - Car X = n·(H_VISIBLE_AREA/4), i.e. 0, 160, 320, 480.
  - Car Y per lane.
  - `o_Hit` = `o_Win` = 0, state = IDLE, frame counter = 0, level = 0.
  - Outputs of cars n ≥ NB_CARS are held at their reset values.
- States:
  - IDLE: cars frozen. If `i_Start` = 1, go to WAIT and clear the frame counter.
  - WAIT: on `i_Frame_Tick`, increment the frame counter. When it reaches FRAME_DIV, clear it, latch frog X/Y and go to MOVE.
  - MOVE: index i = 0..NB_CARS−1, one car per cycle. Update car i X, then go to CHECK.
  - CHECK: index i = 0..NB_CARS−1, one car per cycle. OR the overlap of car i into a sticky hit flag. After the last index:
    - hit → HIT
    - else latched frog Y == 0 → WIN
    - else → WAIT
  - HIT: assert `o_Hit` for one cycle, then IDLE. Car positions are kept.
  - WIN: assert `o_Win` for one cycle, then IDLE.
- Wrap arithmetic uses 11-bit intermediates:
  - Right move: if X + s ≥ H_VISIBLE_AREA, then X + s − H_VISIBLE_AREA; else X + s.
  - Left move: if X < s, then X + H_VISIBLE_AREA − s; else X − s.
- Overlap test, on 11-bit unsigned differences: |carX − frogX| < TILE_SIZE and |carY − frogY| < TILE_SIZE. Wrap is ignored for overlap.
- Boundary rules:
  - `i_Frame_Tick` during MOVE/CHECK/HIT/WIN is dropped and not counted.
  - `i_Start` outside IDLE is ignored.
  - Hit and win detected in the same frame: hit wins.
  - Reset mid-MOVE: all registers return to reset values at the next edge. No partial update survives.

## Timing
- Tick sampled at edge T with the counter reaching FRAME_DIV: state becomes MOVE at T+1.
- Car i X updates at edge T+2+i.
- CHECK occupies edges T+N+2 .. T+2N+1, where N = NB_CARS.
- `o_Hit`/`o_Win` rise at edge T+2N+2 and fall at T+2N+3.
- Total busy window of 2N+3 cycles sits well inside vertical blanking.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `CAR_SPEEDUP_EN` defined:
  - Each WIN increments level, saturating at 7.
  - A HIT clears level to 0.
  - Speed is computed with 4-bit width.
- `CAR_SPEEDUP_EN` not defined: level is a constant 0 and no level register is built.

## Structure
- Shared package `frogger_pkg` holds:
  - state encoding constants: IDLE=0, WAIT=1, MOVE=2, CHECK=3, HIT=4, WIN=5
  - lane direction and base-speed constants
  - default TILE_SIZE and visible-area constants
- Sub-module `car_lane_step`: combinational next-X with wrap. Inputs are X, speed and direction. Instantiated once and shared by the MOVE index.

## Test plan
- Reset, `i_Start`=1, one tick (FRAME_DIV=1):
  - car X values 1, 158, 323, 476
  - Y values 416, 384, 352, 320
  - no pulse
- Wrap:
  - car0 X=639 + tick → 0
  - car1 X=1 + tick → 639
- Frog (10,416), tick → car0 X=1 overlaps, `o_Hit` high exactly 1 cycle at T+2N+2, state IDLE, positions kept.
- Frog (300,0), no overlap, tick → `o_Win` pulse. Then `i_Start` + tick:
  - with `CAR_SPEEDUP_EN`: car0 advances 2 px
  - without: 1 px
- FRAME_DIV=3: cars move only on every 3rd tick. A tick injected during MOVE is ignored.
- Assert `i_Rst_L`=0 during MOVE after car0 updated → all cars back to 0/160/320/480, state IDLE.
